instr_decode_reg: RTL and testbench
===================================

# instr_decode_reg

Instruction register and decode stage for the i281 multicycle CPU; it is the producer side of the control FSM's `opcode_in`/`flags_reg` inputs. It captures the 16-bit instruction word from instruction memory when the FSM's IR-load control bit fires. It decodes the word into the 27-bit one-hot-plus-register-field bus and holds it stable for the rest of the instruction. It also owns the architectural flags register and a retired-instruction counter used by the debug readout.

## Interface
- `COUNT_WIDTH`, default 16: width of the retired-instruction counter.
- `clock` input 1: system clock, all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `ir_load` input 1: capture `instr_in` this cycle; driven by the FSM's IR-enable control bit in the IF state.
- `instr_in` input 16: instruction word from instruction memory.
- `flags_load` input 1: capture `flags_in` this cycle; driven by the FSM's flag-enable bit in ExALU.
- `flags_in` input 4: ALU flags, [0]=Z, [1]=N, [2]=V, [3]=C.
- `opcode_out` output 27: [22:0] one-hot instruction, [26:25] RX, [24:23] RY.
- `imm_out` output 8: instruction bits [7:0], immediate / address / branch offset.
- `flags_reg` output 4: registered flags, same bit order as `flags_in`.
- `retired` output COUNT_WIDTH: count of accepted `ir_load` pulses.

## Operation
- Instruction fields: [15:12] opcode, [11:10] RX, [9:8] RY, [7:0] imm.
- One-hot index (bit of `opcode_out[22:0]`) by opcode:
  - 0000 → 0 (NOOP).
  - 0001 → 1/2/3/4 for [9:8] = 00/01/10/11 (INPUTC/INPUTCF/INPUTD/INPUTDF).
  - 0010 → 5 (MOVE).
  - 0011 → 6 (LOADI/LOADP).
  - 0100 → 7 (ADD); 0101 → 8 (ADDI); 0110 → 9 (SUB); 0111 → 10 (SUBI).
  - 1000 → 11 (LOAD); 1001 → 12 (LOADF); 1010 → 13 (STORE); 1011 → 14 (STOREF).
  - 1100 → 15 (SHIFTL) when [8]=0, 16 (SHIFTR) when [8]=1; bit [9] is ignored.
  - 1101 → 17 (CMP); 1110 → 18 (JUMP).
  - 1111 → 19/20/21/22 for [11:10] = 00/01/10/11 (BRE/BRNE/BRG/BRGE).
- Exactly one bit of [22:0] is set at all times; there is no illegal encoding.
- Decode is combinational from `instr_in`. The result, RX, RY and imm are registered together on `ir_load`, so all four change atomically.
- RX/RY fields are passed through for every opcode, including branches and INPUT. Field swapping for MOVE/LOADF/STORE/STOREF is the FSM's job, not this block's.
- Flags register: loads `flags_in` on `flags_load`, otherwise holds.
- Retired counter: increments by 1 on each `ir_load` and wraps from 2^COUNT_WIDTH−1 to 0.
- State held: IR decode register (35 bits), flags (4 bits), counter.

## Timing
- Reset values: `opcode_out` = 27'h0000001 (NOOP, RX=RY=0), `imm_out` = 0, `flags_reg` = 0, `retired` = 0. Reset is applied immediately and asynchronously.
- `ir_load` high at edge N: outputs reflect `instr_in` sampled at edge N, valid after edge N; latency is 1 cycle. Outputs are held until the next `ir_load`, independent of `instr_in` changes.
- `flags_load` high at edge N: `flags_reg` shows the new value after edge N. An FSM branch decision in ID following ExALU therefore sees the updated flags.
- `ir_load` and `flags_load` in the same cycle are independent; both registers update.
- `ir_load` held for consecutive cycles: the IR reloads and the counter increments every cycle.
- Reset asserted mid-instruction: all outputs return to reset values. After release, nothing changes until the next load pulse.

## Test plan
- Reset, then idle with no loads → `opcode_out`=27'h0000001, `flags_reg`=0, `retired`=0, stable for 10 cycles while `instr_in` toggles randomly.
- `ir_load` with `instr_in`=16'h4E05 (ADD, RX=3, RY=2) → next cycle `opcode_out` has bit7=1, [26:25]=3, [24:23]=2, `imm_out`=8'h05, `retired`=1.
- Sweep all 16 opcodes × all [11:8] values (256 words) → correct single one-hot bit per the table every time, popcount([22:0]) = 1. Include 16'hF8FE → BRG (bit21) with `imm_out`=8'hFE, and 16'hC100 → SHIFTR (bit16).
- `flags_load` and `ir_load` in the same cycle with `flags_in`=4'b0010 → both update. Then hold both loads low for 5 cycles with `flags_in` changing → `flags_reg` stays 4'b0010.
- With COUNT_WIDTH=4, apply 17 `ir_load` pulses → `retired` sequence reaches 15, wraps to 0, ends at 1.
- Assert `reset` between clock edges after loading 16'hA5C3 (STORE) → outputs immediately return to NOOP / 0. The next `ir_load` of 16'h0000 → `retired`=1.

Source files
------------

// File: rtl/instr_decode_reg.sv
// Instruction register and decode stage for the i281 multicycle CPU.
// Latches and decodes the instruction word, and holds the flags register and a retired-instruction counter.
module instr_decode_reg #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ir_load,
  input  logic [15:0]            instr_in,
  input  logic                   flags_load,
  input  logic [3:0]             flags_in,
  output logic [26:0]            opcode_out,
  output logic [7:0]             imm_out,
  output logic [3:0]             flags_reg,
  output logic [COUNT_WIDTH-1:0] retired
);

  localparam logic [22:0] ONEHOT_NOOP = 23'h000001;

  logic [3:0]  opcode;
  logic [1:0]  rx_d, ry_d;
  logic [7:0]  imm_d;
  logic [22:0] onehot_d;

  logic [22:0]            onehot_q;
  logic [1:0]             rx_q, ry_q;
  logic [7:0]             imm_q;
  logic [3:0]             flags_q;
  logic [COUNT_WIDTH-1:0] retired_q;

  assign opcode = instr_in[15:12];
  assign rx_d   = instr_in[11:10];
  assign ry_d   = instr_in[9:8];
  assign imm_d  = instr_in[7:0];

  always_comb begin
    // NOTE: default first, so every path assigns onehot_d and no latch is inferred.
    onehot_d = '0;
    unique case (opcode)
      4'b0000: onehot_d[0]  = 1'b1;
      4'b0001: onehot_d[5'd1 + 5'(ry_d)] = 1'b1;
      4'b0010: onehot_d[5]  = 1'b1;
      4'b0011: onehot_d[6]  = 1'b1;
      4'b0100: onehot_d[7]  = 1'b1;
      4'b0101: onehot_d[8]  = 1'b1;
      4'b0110: onehot_d[9]  = 1'b1;
      4'b0111: onehot_d[10] = 1'b1;
      4'b1000: onehot_d[11] = 1'b1;
      4'b1001: onehot_d[12] = 1'b1;
      4'b1010: onehot_d[13] = 1'b1;
      4'b1011: onehot_d[14] = 1'b1;
      // Shift direction lives in bit 8 only; bit 9 is don't-care.
      4'b1100: onehot_d[instr_in[8] ? 16 : 15] = 1'b1;
      4'b1101: onehot_d[17] = 1'b1;
      4'b1110: onehot_d[18] = 1'b1;
      4'b1111: onehot_d[5'd19 + 5'(rx_d)] = 1'b1;
      default: onehot_d = ONEHOT_NOOP;
    endcase
  end

  // Decode, fields and counter share one enable so the outputs change atomically.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      onehot_q  <= ONEHOT_NOOP;
      rx_q      <= '0;
      ry_q      <= '0;
      imm_q     <= '0;
      retired_q <= '0;
    end else if (ir_load) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      onehot_q  <= onehot_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      imm_q     <= imm_d;
      retired_q <= retired_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           flags_q <= '0;
    else if (flags_load) flags_q <= flags_in;
  end

  assign opcode_out = {rx_q, ry_q, onehot_q};
  assign imm_out    = imm_q;
  assign flags_reg  = flags_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_instr_decode_reg.sv
// Directed self-checking bench for instr_decode_reg, built with a 4-bit retired counter
// so that counter wrap-around is reachable.
module tb_instr_decode_reg;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          ir_load;
  logic [15:0]   instr_in;
  logic          flags_load;
  logic [3:0]    flags_in;
  logic [26:0]   opcode_out;
  logic [7:0]    imm_out;
  logic [3:0]    flags_reg;
  logic [CW-1:0] retired;

  int pass_cnt  = 0;
  int check_cnt = 0;

  instr_decode_reg #(.COUNT_WIDTH(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .ir_load    (ir_load),
    .instr_in   (instr_in),
    .flags_load (flags_load),
    .flags_in   (flags_in),
    .opcode_out (opcode_out),
    .imm_out    (imm_out),
    .flags_reg  (flags_reg),
    .retired    (retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // One rising edge, then settle away from it.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic int exp_index(input logic [15:0] w);
    case (w[15:12])
      4'h0: return 0;
      4'h1: return 1 + int'(w[9:8]);
      4'h2: return 5;
      4'h3: return 6;
      4'h4: return 7;
      4'h5: return 8;
      4'h6: return 9;
      4'h7: return 10;
      4'h8: return 11;
      4'h9: return 12;
      4'hA: return 13;
      4'hB: return 14;
      4'hC: return w[8] ? 16 : 15;
      4'hD: return 17;
      4'hE: return 18;
      default: return 19 + int'(w[11:10]);
    endcase
  endfunction

  initial begin
    logic [15:0]   w;
    logic [26:0]   exp_op;
    logic [CW-1:0] exp_ret;

    reset = 1'b1; ir_load = 1'b0; flags_load = 1'b0;
    instr_in = 16'h0; flags_in = 4'h0;
    #12 reset = 1'b0;

    check("reset_opcode", 32'(opcode_out), 32'h0000001);
    check("reset_imm",    32'(imm_out),    32'h0);
    check("reset_flags",  32'(flags_reg),  32'h0);
    check("reset_retired", 32'(retired),   32'h0);

    // Idle: no loads, instruction bus toggles.
    for (int i = 0; i < 10; i++) begin
      instr_in = 16'($urandom);
      flags_in = 4'($urandom);
      step();
      check("idle_opcode",  32'(opcode_out), 32'h0000001);
      check("idle_flags",   32'(flags_reg),  32'h0);
      check("idle_retired", 32'(retired),    32'h0);
    end

    // ADD R3,R2,#5.
    instr_in = 16'h4E05; ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    check("add_opcode",  32'(opcode_out), 32'h7000080);
    check("add_imm",     32'(imm_out),    32'h05);
    check("add_retired", 32'(retired),    32'h1);

    // Outputs hold while instr_in changes without a load.
    instr_in = 16'hFFFF;
    step();
    check("hold_opcode", 32'(opcode_out), 32'h7000080);
    check("hold_imm",    32'(imm_out),    32'h05);

    // Simultaneous IR and flags load.
    instr_in = 16'h0000; ir_load = 1'b1; flags_in = 4'b0010; flags_load = 1'b1;
    step();
    ir_load = 1'b0; flags_load = 1'b0;
    check("both_flags",   32'(flags_reg),  32'h2);
    check("both_opcode",  32'(opcode_out), 32'h0000001);
    check("both_retired", 32'(retired),    32'h2);
    for (int i = 0; i < 5; i++) begin
      flags_in = 4'(i * 5 + 1);
      step();
      check("flags_hold", 32'(flags_reg), 32'h2);
    end

    // Sweep every opcode with every [11:8] combination.
    exp_ret = 4'h2;
    for (int op = 0; op < 16; op++) begin
      for (int f = 0; f < 16; f++) begin
        w = {4'(op), 4'(f), ~{4'(op), 4'(f)}};
        instr_in = w; ir_load = 1'b1;
        step();
        ir_load = 1'b0;
        exp_ret = exp_ret + 1'b1;
        exp_op = {w[11:10], w[9:8], 23'(1) << exp_index(w)};
        check($sformatf("sweep_opcode_%04h", w), 32'(opcode_out), 32'(exp_op));
        check("sweep_imm",      32'(imm_out),    32'(w[7:0]));
        check("sweep_popcount", 32'($countones(opcode_out[22:0])), 32'h1);
        check("sweep_retired",  32'(retired),    32'(exp_ret));
      end
    end

    // Named corner words.
    instr_in = 16'hF8FE; ir_load = 1'b1;
    step();
    check("brg_opcode", 32'(opcode_out), 32'h4200000);
    check("brg_imm",    32'(imm_out),    32'hFE);
    instr_in = 16'hC100;
    step();
    ir_load = 1'b0;
    check("shiftr_opcode", 32'(opcode_out), 32'h0810000);

    // Counter wrap over 17 back-to-back loads from a fresh reset.
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    check("wrap_start", 32'(retired), 32'h0);
    ir_load = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      instr_in = 16'(i);
      step();
      check($sformatf("wrap_retired_%0d", i), 32'(retired), 32'(i % 16));
    end
    ir_load = 1'b0;
    check("wrap_end", 32'(retired), 32'h1);

    // STORE R1,R1,#C3 then asynchronous reset between edges.
    instr_in = 16'hA5C3; ir_load = 1'b1; flags_in = 4'hB; flags_load = 1'b1;
    step();
    ir_load = 1'b0; flags_load = 1'b0;
    check("store_opcode", 32'(opcode_out), 32'h2802000);
    check("store_imm",    32'(imm_out),    32'hC3);
    check("store_flags",  32'(flags_reg),  32'hB);
    reset = 1'b1;
    #1;
    check("async_opcode",  32'(opcode_out), 32'h0000001);
    check("async_imm",     32'(imm_out),    32'h0);
    check("async_flags",   32'(flags_reg),  32'h0);
    check("async_retired", 32'(retired),    32'h0);
    step();
    reset = 1'b0;
    instr_in = 16'h4E05;
    step();
    check("post_reset_idle", 32'(opcode_out), 32'h0000001);
    instr_in = 16'h0000; ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    check("post_reset_retired", 32'(retired),    32'h1);
    check("post_reset_opcode",  32'(opcode_out), 32'h0000001);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
